pwm_multi_chan: RTL and testbench

Parametrised multi-channel PWM generator sharing one period counter across `NUM_CH` outputs, with per-channel compare, enable and polarity. All configuration is double-buffered: software writes a staging set and pulses `load`, and the live (shadow) set is replaced only at a period boundary, so no output ever sees a torn or truncated period. It supports edge-aligned and center-aligned (up/down) counting and sits between the AXI register file and the motor/servo output pins.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_multi_chan_if.sv | 36 +++
 rtl/pwm_cmp_chan.sv | 55 +++++
 rtl/pwm_multi_chan.sv | 175 +++++++++++++++++
 tb/tb_pwm_multi_chan.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared types and bounds for the multi-channel PWM generator.
//   pwm_mode_e : counting mode of a period (edge-aligned or center-aligned)
//   dir_e      : direction of the shared counter in center-aligned mode
//   PWM_MAX_CH : largest supported channel count
//   PWM_MAX_W  : largest supported counter width
package pwm_pkg;

  localparam int PWM_MAX_CH = 32;
  localparam int PWM_MAX_W  = 32;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_multi_chan_if.sv
// Configuration and output bundle of pwm_multi_chan.
//   period_in      : staged period in clk cycles
//   hi_in          : staged compare values, channel k at [k*CNT_W +: CNT_W]
//   en_in, inv_in  : staged per-channel enable and polarity invert
//   center_in      : staged mode, 0 = edge-aligned, 1 = center-aligned
//   load           : single-cycle pulse capturing all *_in into staging
//   pwm            : registered PWM outputs
//   period_start   : registered pulse on the first cycle of each period
//   update_pending : staged values are waiting for a period boundary
// master = register file side, slave = PWM generator side.
interface pwm_multi_chan_if #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 32
);

  logic [CNT_W-1:0]        period_in;
  logic [NUM_CH*CNT_W-1:0] hi_in;
  logic [NUM_CH-1:0]       en_in;
  logic [NUM_CH-1:0]       inv_in;
  logic                    center_in;
  logic                    load;
  logic [NUM_CH-1:0]       pwm;
  logic                    period_start;
  logic                    update_pending;

  modport master (
    output period_in, hi_in, en_in, inv_in, center_in, load,
    input  pwm, period_start, update_pending
  );

  modport slave (
    input  period_in, hi_in, en_in, inv_in, center_in, load,
    output pwm, period_start, update_pending
  );

endinterface

// File: rtl/pwm_cmp_chan.sv
// One PWM channel: holds the live compare value, enable and polarity, and
// produces the registered output from the shared period counter.
//   clk, reset : clock and synchronous active-high reset
//   cnt        : shared period counter
//   running    : live period is non-zero (a zero period forces raw low)
//   transfer   : staging-to-live copy strobe from the top level
//   hi_stg     : staged compare value
//   en_stg     : staged enable
//   inv_stg    : staged polarity invert
//   pwm        : registered channel output
module pwm_cmp_chan
  import pwm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt,
  input  logic             running,
  input  logic             transfer,
  input  logic [CNT_W-1:0] hi_stg,
  input  logic             en_stg,
  input  logic             inv_stg,
  output logic             pwm
);

  logic [CNT_W-1:0] hi;
  logic             en;
  logic             inv;
  logic             raw;
  logic             pwm_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi  <= '0;
      en  <= 1'b0;
      inv <= 1'b0;
    end else if (transfer) begin
      hi  <= hi_stg;
      en  <= en_stg;
      inv <= inv_stg;
    end
  end

  // hi >= period naturally gives 100 % because cnt never reaches the period.
  assign raw   = running && (cnt < hi);
  assign pwm_d = en ? (raw ^ inv) : inv;

  // Output stage: one cycle behind the counter
  always_ff @(posedge clk) begin
    if (reset) pwm <= 1'b0;
    else       pwm <= pwm_d;
  end

endmodule

// File: rtl/pwm_multi_chan.sv
// Multi-channel PWM generator with one shared period counter.
// Software writes a staging set and pulses load; the live set is replaced
// only at a period boundary so no output sees a torn period. Supports
// edge-aligned (0..P-1 wrap) and center-aligned (up/down, 2P cycles) modes.
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : configuration inputs and PWM outputs (pwm_multi_chan_if.slave)
module pwm_multi_chan
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  pwm_multi_chan_if.slave bus
);

  if (NUM_CH < 1 || NUM_CH > PWM_MAX_CH) begin : g_bad_num_ch
    $error("pwm_multi_chan: NUM_CH out of range");
  end
  if (CNT_W < 2 || CNT_W > PWM_MAX_W) begin : g_bad_cnt_w
    $error("pwm_multi_chan: CNT_W out of range");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Staging set
  logic [CNT_W-1:0]        stg_period;
  logic [NUM_CH*CNT_W-1:0] stg_hi;
  logic [NUM_CH-1:0]       stg_en;
  logic [NUM_CH-1:0]       stg_inv;
  pwm_mode_e               stg_mode;
  logic                    pending;

  // Live period and mode
  logic [CNT_W-1:0]        period;
  pwm_mode_e               mode;

  // Counter FSM
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  dir_e                    dir;
  dir_e                    dir_nxt;

  logic                    running;
  logic                    at_top;
  logic                    boundary;
  logic                    transfer;
  logic                    period_start_d;
  logic                    period_start_p1;
  logic [NUM_CH-1:0]       pwm_p1;

  // A later load always overwrites staging, even while a transfer is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_period <= '0;
      stg_hi     <= '0;
      stg_en     <= '0;
      stg_inv    <= '0;
      stg_mode   <= EDGE;
      pending    <= 1'b0;
    end else if (bus.load) begin
      stg_period <= bus.period_in;
      stg_hi     <= bus.hi_in;
      stg_en     <= bus.en_in;
      stg_inv    <= bus.inv_in;
      stg_mode   <= bus.center_in ? CENTER : EDGE;
      pending    <= 1'b1;
    end else if (transfer) begin
      pending    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period <= '0;
      mode   <= EDGE;
    end else if (transfer) begin
      period <= stg_period;
      mode   <= stg_mode;
    end
  end

  assign running = (period != '0);
  // The P-1 term only matters when the period is non-zero, so its wrap at
  // P=0 is never observed.
  assign at_top  = running && (cnt == (period - CNT_ONE));

  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (!running) begin
      boundary = 1'b1;
      cnt_nxt  = '0;
      dir_nxt  = UP;
    end else if (mode == EDGE) begin
      dir_nxt = UP;
      if (at_top) begin
        boundary = 1'b1;
        cnt_nxt  = '0;
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end else begin
      // Center mode: the count holds for one cycle at each turning point,
      // giving a 2P-cycle period with the boundary at the valley.
      case (dir)
        UP: begin
          if (at_top) dir_nxt = DOWN;
          else        cnt_nxt = cnt + CNT_ONE;
        end
        DOWN: begin
          if (cnt == '0) begin
            boundary = 1'b1;
            dir_nxt  = UP;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        default: begin
          dir_nxt = UP;
        end
      endcase
    end

    // A load in the boundary cycle defers the copy to the next boundary so
    // the freshly written values are the ones transferred.
    transfer = boundary && pending && !bus.load;
    if (transfer) begin
      cnt_nxt = '0;
      dir_nxt = UP;
    end
  end

  assign period_start_d = running && (cnt == '0) && ((mode == EDGE) || (dir == UP));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      dir <= UP;
    end else begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

  // Output stage: period_start aligned with the registered channel outputs
  always_ff @(posedge clk) begin
    if (reset) period_start_p1 <= 1'b0;
    else       period_start_p1 <= period_start_d;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_cmp_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .cnt      (cnt),
      .running  (running),
      .transfer (transfer),
      .hi_stg   (stg_hi[k*CNT_W +: CNT_W]),
      .en_stg   (stg_en[k]),
      .inv_stg  (stg_inv[k]),
      .pwm      (pwm_p1[k])
    );
  end

  assign bus.pwm            = pwm_p1;
  assign bus.period_start   = period_start_p1;
  assign bus.update_pending = pending;

endmodule

// File: tb/tb_pwm_multi_chan.sv
// Self-checking bench for pwm_multi_chan with 4 channels of 8-bit counters.
module tb_pwm_multi_chan;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pwm_multi_chan_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  pwm_multi_chan #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Live configuration as the bench expects it to be
  int         cfg_p;
  logic [7:0] cfg_hi [4];
  logic [3:0] cfg_en;
  logic [3:0] cfg_inv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int p, input logic [NUM_CH*CNT_W-1:0] hi,
                         input logic [3:0] en, input logic [3:0] inv, input logic ctr);
    bus.period_in = CNT_W'(p);
    bus.hi_in     = hi;
    bus.en_in     = en;
    bus.inv_in    = inv;
    bus.center_in = ctr;
  endtask

  function automatic logic [3:0] exp_pwm(input int c);
    logic [3:0] r;
    logic       raw;
    r = '0;
    for (int ch = 0; ch < 4; ch++) begin
      raw   = (cfg_p != 0) && (c < int'(cfg_hi[ch]));
      r[ch] = cfg_en[ch] ? (raw ^ cfg_inv[ch]) : cfg_inv[ch];
    end
    return r;
  endfunction

  function automatic int ctr_cnt(input int j);
    int m;
    m = j % 16;
    return (m < 8) ? m : 15 - m;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.load = 1'b0;
    set_cfg(0, '0, 4'h0, 4'h0, 1'b0);
    tick();
    tick();
    checks++; if (bus.pwm !== 4'b0000) begin errors++; $display("FAIL reset_pwm: got %b want 0000", bus.pwm); end
    checks++; if (bus.period_start !== 1'b0) begin errors++; $display("FAIL reset_period_start: got %b want 0", bus.period_start); end
    checks++; if (bus.update_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", bus.update_pending); end
    reset = 1'b0;
    tick();
    checks++; if (bus.pwm !== 4'b0000) begin errors++; $display("FAIL reset_idle_pwm: got %b want 0000", bus.pwm); end
  endtask

  task automatic test_edge_basic();
    int hc [4] = '{default: 0};
    int ps_n = 0;
    int e;
    set_cfg(10, {8'd15, 8'd10, 8'd3, 8'd0}, 4'hF, 4'h0, 1'b0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    checks++; if (bus.update_pending !== 1'b1) begin errors++; $display("FAIL edge_pending_rise: got %b want 1", bus.update_pending); end
    tick();
    checks++; if (bus.update_pending !== 1'b0) begin errors++; $display("FAIL edge_pending_fall: got %b want 0", bus.update_pending); end
    checks++; if (bus.period_start !== 1'b0) begin errors++; $display("FAIL edge_early_start: got %b want 0", bus.period_start); end
    tick();
    cfg_p = 10; cfg_hi = '{8'd0, 8'd3, 8'd10, 8'd15}; cfg_en = 4'hF; cfg_inv = 4'h0;
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(10); exp_q.push_back(10);
    exp_q.push_back(1);
    checks++; if (bus.period_start !== 1'b1) begin errors++; $display("FAIL edge_first_start: got %b want 1", bus.period_start); end
    checks++; if (bus.pwm !== exp_pwm(0)) begin errors++; $display("FAIL edge_first_pwm: got %b want %b", bus.pwm, exp_pwm(0)); end
    for (int k = 0; k < 10; k++) begin
      for (int ch = 0; ch < 4; ch++) hc[ch] += int'(bus.pwm[ch]);
      ps_n += int'(bus.period_start);
      tick();
    end
    for (int ch = 0; ch < 4; ch++) begin
      e = exp_q.pop_front();
      checks++; if (hc[ch] !== e) begin errors++; $display("FAIL edge_high_count ch%0d: got %0d want %0d", ch, hc[ch], e); end
    end
    e = exp_q.pop_front();
    checks++; if (ps_n !== e) begin errors++; $display("FAIL edge_start_count: got %0d want %0d", ps_n, e); end
    checks++; if (bus.period_start !== 1'b1) begin errors++; $display("FAIL edge_start_period10: got %b want 1", bus.period_start); end
  endtask

  task automatic test_shadow_timing();
    int c0 = 0;
    int c1 = 0;
    int e;
    exp_q.push_back(3); exp_q.push_back(7);
    for (int k = 0; k < 20; k++) begin
      if (k < 10) c0 += int'(bus.pwm[1]);
      else        c1 += int'(bus.pwm[1]);
      if (k >= 4 && k <= 8) begin
        checks++; if (bus.update_pending !== 1'b1) begin errors++; $display("FAIL shadow_pending k%0d: got %b want 1", k, bus.update_pending); end
      end
      if (k == 9) begin
        checks++; if (bus.update_pending !== 1'b0) begin errors++; $display("FAIL shadow_pending_fall: got %b want 0", bus.update_pending); end
      end
      if (k == 10) begin
        checks++; if (bus.period_start !== 1'b1) begin errors++; $display("FAIL shadow_start: got %b want 1", bus.period_start); end
      end
      if (k == 3) begin
        set_cfg(10, {8'd15, 8'd10, 8'd7, 8'd0}, 4'hF, 4'h0, 1'b0);
        bus.load = 1'b1;
      end
      if (k == 4) bus.load = 1'b0;
      tick();
    end
    cfg_hi[1] = 8'd7;
    e = exp_q.pop_front();
    checks++; if (c0 !== e) begin errors++; $display("FAIL shadow_old_duty: got %0d want %0d", c0, e); end
    e = exp_q.pop_front();
    checks++; if (c1 !== e) begin errors++; $display("FAIL shadow_new_duty: got %0d want %0d", c1, e); end
  endtask

  task automatic test_load_on_boundary();
    int cw [3] = '{default: 0};
    int e;
    exp_q.push_back(7); exp_q.push_back(7); exp_q.push_back(5);
    for (int k = 0; k < 30; k++) begin
      cw[k / 10] += int'(bus.pwm[1]);
      if (k >= 4 && k <= 18) begin
        checks++; if (bus.update_pending !== 1'b1) begin errors++; $display("FAIL lob_pending k%0d: got %b want 1", k, bus.update_pending); end
      end
      if (k == 19) begin
        checks++; if (bus.update_pending !== 1'b0) begin errors++; $display("FAIL lob_pending_fall: got %b want 0", bus.update_pending); end
      end
      if (k == 10 || k == 20) begin
        checks++; if (bus.period_start !== 1'b1) begin errors++; $display("FAIL lob_start k%0d: got %b want 1", k, bus.period_start); end
      end
      if (k == 3) begin
        set_cfg(10, {8'd15, 8'd10, 8'd6, 8'd0}, 4'hF, 4'h0, 1'b0);
        bus.load = 1'b1;
      end
      if (k == 8) begin
        set_cfg(10, {8'd15, 8'd10, 8'd5, 8'd0}, 4'hF, 4'h0, 1'b0);
        bus.load = 1'b1;
      end
      if (k == 4 || k == 9) bus.load = 1'b0;
      tick();
    end
    cfg_hi[1] = 8'd5;
    for (int w = 0; w < 3; w++) begin
      e = exp_q.pop_front();
      checks++; if (cw[w] !== e) begin errors++; $display("FAIL lob_duty window%0d: got %0d want %0d", w, cw[w], e); end
    end
  endtask

  task automatic test_center();
    int c0 = 0;
    int e;
    for (int k = 0; k < 42; k++) begin
      if (k >= 10) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.period_start, bus.pwm} !== 5'(e)) begin
          errors++;
          $display("FAIL center_sample j%0d: got ps=%b pwm=%b want ps=%b pwm=%b",
                   k - 10, bus.period_start, bus.pwm, e[4], e[3:0]);
        end
        if (k - 10 < 16) c0 += int'(bus.pwm[0]);
      end
      if (k == 3) begin
        set_cfg(8, {8'd5, 8'd0, 8'd8, 8'd3}, 4'hF, 4'h0, 1'b1);
        bus.load = 1'b1;
        cfg_p = 8; cfg_hi = '{8'd3, 8'd8, 8'd0, 8'd5}; cfg_en = 4'hF; cfg_inv = 4'h0;
        for (int j = 0; j < 32; j++)
          exp_q.push_back(((j % 16 == 0) ? 16 : 0) + int'(exp_pwm(ctr_cnt(j))));
        exp_q.push_back(6);
      end
      if (k == 4) bus.load = 1'b0;
      tick();
    end
    e = exp_q.pop_front();
    checks++; if (c0 !== e) begin errors++; $display("FAIL center_ch0_high: got %0d want %0d", c0, e); end
  endtask

  task automatic test_polarity_p0();
    int e;
    for (int k = 0; k < 42; k++) begin
      if (k >= 1 && k <= 14) begin
        checks++; if (bus.update_pending !== 1'b1) begin errors++; $display("FAIL pol_pending k%0d: got %b want 1", k, bus.update_pending); end
      end
      if (k == 15) begin
        checks++; if (bus.update_pending !== 1'b0) begin errors++; $display("FAIL pol_pending_fall: got %b want 0", bus.update_pending); end
      end
      if ((k >= 16 && k <= 27) || (k >= 34 && k <= 41)) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.period_start, bus.pwm} !== 5'(e)) begin
          errors++;
          $display("FAIL pol_sample k%0d: got ps=%b pwm=%b want ps=%b pwm=%b",
                   k, bus.period_start, bus.pwm, e[4], e[3:0]);
        end
      end
      if (k == 0) begin
        set_cfg(6, {8'd6, 8'd4, 8'd3, 8'd2}, 4'b1011, 4'b0101, 1'b0);
        bus.load = 1'b1;
        cfg_p = 6; cfg_hi = '{8'd2, 8'd3, 8'd4, 8'd6}; cfg_en = 4'b1011; cfg_inv = 4'b0101;
        for (int m = 0; m < 12; m++)
          exp_q.push_back(((m % 6 == 0) ? 16 : 0) + int'(exp_pwm(m % 6)));
      end
      if (k == 28) begin
        set_cfg(0, {8'd6, 8'd4, 8'd3, 8'd2}, 4'b1011, 4'b0101, 1'b0);
        bus.load = 1'b1;
        cfg_p = 0;
        for (int m = 0; m < 8; m++) exp_q.push_back(int'(exp_pwm(0)));
      end
      if (k == 1 || k == 29) bus.load = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    checks++; if (bus.pwm !== 4'b0101) begin errors++; $display("FAIL rst_pre_pwm: got %b want 0101", bus.pwm); end
    set_cfg(4, {4{8'd2}}, 4'hF, 4'h0, 1'b0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    checks++; if (bus.update_pending !== 1'b1) begin errors++; $display("FAIL rst_pre_pending: got %b want 1", bus.update_pending); end
    reset = 1'b1;
    tick();
    checks++; if (bus.pwm !== 4'b0000) begin errors++; $display("FAIL rst_mid_pwm: got %b want 0000", bus.pwm); end
    checks++; if (bus.period_start !== 1'b0) begin errors++; $display("FAIL rst_mid_start: got %b want 0", bus.period_start); end
    checks++; if (bus.update_pending !== 1'b0) begin errors++; $display("FAIL rst_mid_pending: got %b want 0", bus.update_pending); end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({bus.period_start, bus.update_pending, bus.pwm} !== 6'b0) begin
        errors++;
        $display("FAIL rst_after k%0d: got ps=%b pend=%b pwm=%b want all 0",
                 k, bus.period_start, bus.update_pending, bus.pwm);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_edge_basic();
    test_shadow_timing();
    test_load_on_boundary();
    test_center();
    test_polarity_p0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
